b1_event_capture: RTL and testbench

B1_EVENT_CAPTURE -- requirements
Module: b1_event_capture

---
 rtl/b1_pkg.sv | 42 ++++
 rtl/b1_ev_fifo.sv | 79 +++++++
 rtl/b1_event_capture.sv | 136 +++++++++++++
 tb/tb_b1_event_capture.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/b1_pkg.sv
`default_nettype none
// ============================================================================
// Module   : b1_pkg
// Brief    : Shared widths, event field offsets and event packing helper for
//            the b1 event capture block.
// Revision : 1.0 - initial release
// ============================================================================
package b1_pkg;

  // Sample vector {pd, pe, pf, pg}, sequence tag and packed event widths
  localparam int VEC_W = 4;
  localparam int SEQ_W = 4;
  localparam int EV_W  = 8;

  // Bit positions of each field inside a packed event {seq, pd, pe, pf, pg}
  localparam int EV_PG_BIT  = 0;
  localparam int EV_PF_BIT  = 1;
  localparam int EV_PE_BIT  = 2;
  localparam int EV_PD_BIT  = 3;
  localparam int EV_SEQ_LSB = 4;

  // Bit positions of each flag inside a sample vector {pd, pe, pf, pg}
  localparam int VEC_PG_BIT = 0;
  localparam int VEC_PF_BIT = 1;
  localparam int VEC_PE_BIT = 2;
  localparam int VEC_PD_BIT = 3;

  // Build an event word from its sequence tag and sample vector
  function automatic logic [EV_W-1:0] pack_event(input logic [SEQ_W-1:0] seq,
                                                 input logic [VEC_W-1:0] vec);
    logic [EV_W-1:0] ev;
    ev = '0;
    ev[EV_SEQ_LSB +: SEQ_W] = seq;
    ev[EV_PD_BIT]           = vec[VEC_PD_BIT];
    ev[EV_PE_BIT]           = vec[VEC_PE_BIT];
    ev[EV_PF_BIT]           = vec[VEC_PF_BIT];
    ev[EV_PG_BIT]           = vec[VEC_PG_BIT];
    return ev;
  endfunction

endpackage : b1_pkg
`default_nettype wire

// File: rtl/b1_ev_fifo.sv
`default_nettype none
// ============================================================================
// Module   : b1_ev_fifo
// Brief    : Small synchronous event FIFO. A push into a full FIFO is only
//            taken when a pop happens in the same cycle; a pop on an empty
//            FIFO is ignored. Storage is cleared by reset so the head word
//            reads zero after reset.
// Revision : 1.0 - initial release
// ============================================================================
module b1_ev_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int EV_W       = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [EV_W-1:0] i_wdata,
  output logic [EV_W-1:0] o_rdata,
  output logic            o_full,
  output logic            o_empty
);

  localparam int c_ADDR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [c_ADDR_W:0] c_FULL_CNT = (c_ADDR_W + 1)'(FIFO_DEPTH);

  logic [EV_W-1:0]     r_mem [FIFO_DEPTH];
  logic [c_ADDR_W-1:0] r_wr_ptr;
  logic [c_ADDR_W-1:0] r_rd_ptr;
  logic [c_ADDR_W:0]   r_count;

  logic w_wr_en;
  logic w_rd_en;

  assign o_full  = (r_count == c_FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_rdata = r_mem[r_rd_ptr];

  // A full FIFO still accepts a write when the head leaves in the same cycle
  assign w_wr_en = i_push && (!o_full || i_pop);
  assign w_rd_en = i_pop && !o_empty;

  // Storage array and write pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
    end else if (w_wr_en) begin
      r_mem[r_wr_ptr] <= i_wdata;
      r_wr_ptr        <= r_wr_ptr + 1'b1;
    end
  end

  // Read pointer advances on every effective pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
    end else if (w_rd_en) begin
      r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Occupancy tracks the net effect of write and read in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : b1_ev_fifo
`default_nettype wire

// File: rtl/b1_event_capture.sv
`default_nettype none
// ============================================================================
// Module   : b1_event_capture
// Brief    : Watches accepted {pd,pe,pf,pg} samples, queues an event with a
//            sequence tag whenever the vector changes (or on the first
//            sample), keeps saturating pe/pf counters and sticky error and
//            overflow flags.
// Revision : 1.0 - initial release
// ============================================================================
module b1_event_capture
  import b1_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             pd,
  input  logic             pe,
  input  logic             pf,
  input  logic             pg,
  input  logic             clr,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [EV_W-1:0]  ev_data,
  output logic [CNT_W-1:0] pe_cnt,
  output logic [CNT_W-1:0] pf_cnt,
  output logic             err,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  logic [VEC_W-1:0] r_prev_vec;
  logic             r_has_prev;
  logic [SEQ_W-1:0] r_seq;
  logic [CNT_W-1:0] r_pe_cnt;
  logic [CNT_W-1:0] r_pf_cnt;
  logic             r_err;
  logic             r_ovf;

  logic [VEC_W-1:0] w_vec;
  logic             w_event;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push_ok;
  logic             w_drop;
  logic [EV_W-1:0]  w_ev_word;

  assign w_vec     = {pd, pe, pf, pg};
  assign w_event   = in_valid && (!r_has_prev || (w_vec != r_prev_vec));
  assign w_pop     = !w_empty && ev_ready;
  assign w_push_ok = w_event && (!w_full || w_pop);
  assign w_drop    = w_event && w_full && !w_pop;
  assign w_ev_word = pack_event(r_seq, w_vec);

  assign ev_valid = !w_empty;
  assign pe_cnt   = r_pe_cnt;
  assign pf_cnt   = r_pf_cnt;
  assign err      = r_err;
  assign ovf      = r_ovf;

  b1_ev_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .EV_W       (EV_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_event),
    .i_pop   (w_pop),
    .i_wdata (w_ev_word),
    .o_rdata (ev_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Change detector history; untouched by clr so the next sample still compares
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_vec <= '0;
      r_has_prev <= 1'b0;
    end else if (in_valid) begin
      r_prev_vec <= w_vec;
      r_has_prev <= 1'b1;
    end
  end

  // Sequence tag only moves when an event actually lands in the FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seq <= '0;
    end else if (w_push_ok) begin
      r_seq <= r_seq + 1'b1;
    end
  end

  // Saturating occurrence counters; clr has priority over a same-cycle count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pe_cnt <= '0;
      r_pf_cnt <= '0;
    end else if (clr) begin
      r_pe_cnt <= '0;
      r_pf_cnt <= '0;
    end else if (in_valid) begin
      if (pe && (r_pe_cnt != c_CNT_MAX)) begin
        r_pe_cnt <= r_pe_cnt + 1'b1;
      end
      if (pf && (r_pf_cnt != c_CNT_MAX)) begin
        r_pf_cnt <= r_pf_cnt + 1'b1;
      end
    end
  end

  // Sticky error and overflow flags; clr has priority over a same-cycle set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
      r_ovf <= 1'b0;
    end else if (clr) begin
      r_err <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (in_valid && (pg == pd)) begin
        r_err <= 1'b1;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

endmodule : b1_event_capture
`default_nettype wire

// File: tb/tb_b1_event_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_b1_event_capture
// Brief    : Self-checking bench for b1_event_capture against a queue-based
//            behavioural model of the event capture rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_b1_event_capture;

  localparam int DEPTH   = 4;
  localparam int CW      = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          pd = 1'b0, pe = 1'b0, pf = 1'b0, pg = 1'b0;
  logic          clr = 1'b0;
  logic          ev_ready = 1'b0;
  logic          ev_valid;
  logic [7:0]    ev_data;
  logic [CW-1:0] pe_cnt;
  logic [CW-1:0] pf_cnt;
  logic          err;
  logic          ovf;

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model state
  logic [7:0] mq[$];
  int         m_seq;
  logic [3:0] m_prev;
  bit         m_has;
  int         m_pe, m_pf;
  bit         m_err, m_ovf;

  b1_event_capture #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .pd       (pd),
    .pe       (pe),
    .pf       (pf),
    .pg       (pg),
    .clr      (clr),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_data  (ev_data),
    .pe_cnt   (pe_cnt),
    .pf_cnt   (pf_cnt),
    .err      (err),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_seq  = 0;
    m_prev = 4'h0;
    m_has  = 1'b0;
    m_pe   = 0;
    m_pf   = 0;
    m_err  = 1'b0;
    m_ovf  = 1'b0;
  endtask

  // One clock edge of the model, using the inputs present at that edge
  task automatic model_step(input bit v, input logic [3:0] vec, input bit rdy, input bit c);
    bit pop, ev, drop;
    pop  = (mq.size() != 0) && rdy;
    ev   = v && (!m_has || (vec != m_prev));
    drop = 1'b0;
    if (ev && (mq.size() == DEPTH) && !pop) drop = 1'b1;
    if (pop) void'(mq.pop_front());
    if (ev && !drop) begin
      mq.push_back({4'(m_seq), vec});
      m_seq = (m_seq + 1) % 16;
    end
    if (v) begin
      m_prev = vec;
      m_has  = 1'b1;
    end
    if (c) begin
      m_pe = 0; m_pf = 0; m_err = 1'b0; m_ovf = 1'b0;
    end else begin
      if (v && vec[2] && m_pe < CNT_MAX) m_pe++;
      if (v && vec[1] && m_pf < CNT_MAX) m_pf++;
      if (v && (vec[0] == vec[3])) m_err = 1'b1;
      if (drop) m_ovf = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("ev_valid", 32'(ev_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("ev_data", 32'(ev_data), 32'(mq[0]));
    chk("pe_cnt", 32'(pe_cnt), 32'(m_pe));
    chk("pf_cnt", 32'(pf_cnt), 32'(m_pf));
    chk("err", 32'(err), 32'(m_err));
    chk("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  // Apply one cycle of inputs, advance the model and compare after the edge
  task automatic cyc(input bit v, input logic [3:0] vec, input bit rdy, input bit c);
    @(negedge clk);
    in_valid = v;
    {pd, pe, pf, pg} = vec;
    ev_ready = rdy;
    clr = c;
    @(posedge clk);
    model_step(v, vec, rdy, c);
    #1;
    check_all();
  endtask

  // Assert reset between edges and check the outputs clear without a clock
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    ev_ready = 1'b0;
    clr = 1'b0;
    #1;
    model_reset();
    chk("rst_ev_valid", 32'(ev_valid), 32'd0);
    chk("rst_ev_data", 32'(ev_data), 32'd0);
    chk("rst_pe_cnt", 32'(pe_cnt), 32'd0);
    chk("rst_pf_cnt", 32'(pf_cnt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] rv;
    logic [3:0] last;
    model_reset();
    do_reset();

    // First sample after reset: pd only -> event 8'h08, no error
    cyc(1, 4'b1000, 0, 0);
    chk("first_ev_data", 32'(ev_data), 32'h08);
    chk("first_err", 32'(err), 32'd0);

    // Repeated vector 1001 yields a single event
    do_reset();
    repeat (3) cyc(1, 4'b1001, 0, 0);
    cyc(0, 4'b0000, 1, 0);
    chk("repeat_empty", 32'(ev_valid), 32'd0);
    chk("repeat_pe_cnt", 32'(pe_cnt), 32'd0);

    // Five distinct events with no consumer: four queue, one drops
    do_reset();
    cyc(1, 4'b0001, 0, 0);
    cyc(1, 4'b0010, 0, 0);
    cyc(1, 4'b0011, 0, 0);
    cyc(1, 4'b0100, 0, 0);
    cyc(1, 4'b0101, 0, 0);
    chk("full_ovf", 32'(ovf), 32'd1);
    chk("full_head", 32'(ev_data), 32'h01);
    repeat (5) cyc(0, 4'b0000, 1, 0);

    // Full FIFO with simultaneous pop and push
    cyc(0, 4'b0000, 0, 1);
    cyc(1, 4'b0110, 0, 0);
    cyc(1, 4'b0111, 0, 0);
    cyc(1, 4'b1010, 0, 0);
    cyc(1, 4'b1011, 0, 0);
    cyc(1, 4'b1100, 1, 0);
    chk("pushpop_ovf", 32'(ovf), 32'd0);
    chk("pushpop_occ", 32'(mq.size()), 32'(DEPTH));
    repeat (5) cyc(0, 4'b0000, 1, 0);

    // Counter saturation, then clr beats a same-cycle increment
    repeat (260) cyc(1, 4'b0110, 1, 0);
    chk("sat_pe", 32'(pe_cnt), 32'd255);
    chk("sat_pf", 32'(pf_cnt), 32'd255);
    cyc(1, 4'b0100, 1, 1);
    chk("clr_pe", 32'(pe_cnt), 32'd0);
    chk("clr_pf", 32'(pf_cnt), 32'd0);

    // pd=pg sets err; reset mid-drain clears everything at once
    cyc(1, 4'b1001, 0, 0);
    chk("err_set", 32'(err), 32'd1);
    cyc(1, 4'b1011, 0, 0);
    cyc(1, 4'b0011, 1, 0);
    do_reset();
    cyc(1, 4'b0011, 0, 0);
    chk("post_rst_seq0", 32'(ev_data), 32'h03);

    // Randomised traffic against the model
    last = 4'h0;
    for (int i = 0; i < 600; i++) begin
      rv = ($urandom_range(0, 1) == 0) ? last : 4'($urandom_range(0, 15));
      last = rv;
      if (i == 300) do_reset();
      cyc($urandom_range(0, 3) != 0, rv, $urandom_range(0, 2) == 0,
          $urandom_range(0, 39) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_b1_event_capture
`default_nettype wire
